// File: rtl/btb_predictor_pkg.sv
// Shared types for the branch target buffer.
// FSM states and 2-bit direction counter encodings.
package btb_predictor_pkg;

  typedef enum logic {
    BTB_CLEAR,
    BTB_RUN
  } btb_state_t;

  localparam logic [1:0] CNT_SNT = 2'b00;
  localparam logic [1:0] CNT_WNT = 2'b01;
  localparam logic [1:0] CNT_WT  = 2'b10;
  localparam logic [1:0] CNT_ST  = 2'b11;

endpackage

// File: rtl/btb_predictor_sat_cnt.sv
// Next value of a 2-bit saturating direction counter.
// Pure combinational; used on the BTB update path.
module btb_sat_cnt
  import btb_predictor_pkg::*;
(
  input  logic [1:0] cur,
  input  logic       taken,
  output logic [1:0] nxt
);

  always_comb begin
    nxt = cur;
    if (taken) begin
      if (cur != CNT_ST) nxt = cur + 2'd1;
    end else begin
      if (cur != CNT_SNT) nxt = cur - 2'd1;
    end
  end

endmodule

// File: rtl/btb_predictor.sv
// Direct-mapped BTB with 2-bit counters, async-read lookup,
// single write port shared by training and the clear walk.
module btb_predictor
  import btb_predictor_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int TAG_W   = 6,
  parameter int ADDR_W  = 32,
  parameter int CNT_W   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] lk_pc_i,
  output logic              lk_hit_o,
  output logic              lk_taken_o,
  output logic [ADDR_W-1:0] lk_target_o,
  input  logic              upd_valid_i,
  input  logic [ADDR_W-1:0] upd_pc_i,
  input  logic              upd_taken_i,
  input  logic [ADDR_W-1:0] upd_target_i,
  input  logic              flush_i,
  output logic              busy_o
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_L = IDX_W + 2;
  localparam int TAG_H = IDX_W + TAG_W + 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(ENTRIES - 1);

  typedef struct packed {
    logic              v;
    logic [TAG_W-1:0]  tag;
    logic [ADDR_W-1:0] ta;
    logic [CNT_W-1:0]  cnt;
  } entry_t;

  entry_t mem [ENTRIES];

  btb_state_t state, state_nxt;
  logic [IDX_W-1:0] ptr, ptr_nxt;

  logic             we;
  logic [IDX_W-1:0] waddr;
  entry_t           wdata;

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  entry_t           lk_e, up_e;
  logic             up_hit;
  logic [1:0]       cnt_nxt;

  assign lk_idx = lk_pc_i[IDX_W+1:2];
  assign lk_tag = lk_pc_i[TAG_H:TAG_L];
  assign up_idx = upd_pc_i[IDX_W+1:2];
  assign up_tag = upd_pc_i[TAG_H:TAG_L];

  logic unused_pc;
  assign unused_pc = ^{lk_pc_i[1:0], lk_pc_i[ADDR_W-1:TAG_H+1],
                       upd_pc_i[1:0], upd_pc_i[ADDR_W-1:TAG_H+1]};

  assign lk_e = mem[lk_idx];
  assign up_e = mem[up_idx];

  assign busy_o      = (state == BTB_CLEAR);
  assign lk_hit_o    = !busy_o && lk_e.v && (lk_e.tag == lk_tag);
  assign lk_taken_o  = lk_hit_o && lk_e.cnt[1];
  assign lk_target_o = lk_hit_o ? lk_e.ta : '0;

  assign up_hit = up_e.v && (up_e.tag == up_tag);

  btb_sat_cnt u_sat_cnt (
    .cur   (up_e.cnt),
    .taken (upd_taken_i),
    .nxt   (cnt_nxt)
  );

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    we        = 1'b0;
    waddr     = ptr;
    wdata     = '0;
    unique case (state)
      BTB_CLEAR: begin
        we        = 1'b1;
        wdata.cnt = CNT_WNT;
        if (ptr == LAST) begin
          state_nxt = BTB_RUN;
          ptr_nxt   = '0;
        end else begin
          ptr_nxt = ptr + 1'b1;
        end
      end
      BTB_RUN: begin
        if (flush_i) begin
          state_nxt = BTB_CLEAR;
          ptr_nxt   = '0;
        end else if (upd_valid_i) begin
          waddr = up_idx;
          if (up_hit) begin
            we        = 1'b1;
            wdata     = up_e;
            wdata.cnt = cnt_nxt;
            if (upd_taken_i) wdata.ta = upd_target_i;
          end else if (upd_taken_i) begin
            we        = 1'b1;
            wdata.v   = 1'b1;
            wdata.tag = up_tag;
            wdata.ta  = upd_target_i;
            wdata.cnt = CNT_WT;
          end
        end
      end
      default: state_nxt = BTB_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BTB_CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // RAM storage carries no reset; the clear walk initialises it.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

endmodule

// File: tb/tb_btb_predictor.sv
// Randomised bench for btb_predictor against a table model
// plus directed allocate/saturation/alias/flush sequences.
module tb_btb_predictor;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc;
  logic        hit, tk;
  logic [31:0] tgt;
  logic        uv;
  logic [31:0] upc;
  logic        ut;
  logic [31:0] utgt;
  logic        fl;
  logic        busy;

  btb_predictor dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .lk_pc_i      (pc),
    .lk_hit_o     (hit),
    .lk_taken_o   (tk),
    .lk_target_o  (tgt),
    .upd_valid_i  (uv),
    .upd_pc_i     (upc),
    .upd_taken_i  (ut),
    .upd_target_i (utgt),
    .flush_i      (fl),
    .busy_o       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  bit          mv   [64];
  int          mtag [64];
  logic [31:0] mta  [64];
  int          mcnt [64];
  int          busy_cnt;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp,
               $time);
    end
  endtask

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 2) % 64);
  endfunction

  function automatic int tag_of(input logic [31:0] a);
    return int'((a >> 8) % 64);
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    return busy_cnt == 0 && mv[idx_of(a)] && mtag[idx_of(a)] == tag_of(a);
  endfunction

  task automatic model_edge();
    int i, t;
    i = idx_of(upc);
    t = tag_of(upc);
    if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0)
        for (int k = 0; k < 64; k++) mv[k] = 1'b0;
    end else if (fl) begin
      busy_cnt = 64;
    end else if (uv) begin
      if (mv[i] && mtag[i] == t) begin
        if (ut) begin
          mcnt[i] = (mcnt[i] == 3) ? 3 : mcnt[i] + 1;
          mta[i]  = utgt;
        end else begin
          mcnt[i] = (mcnt[i] == 0) ? 0 : mcnt[i] - 1;
        end
      end else if (ut) begin
        mv[i]   = 1'b1;
        mtag[i] = t;
        mta[i]  = utgt;
        mcnt[i] = 2;
      end
    end
  endtask

  task automatic cycle();
    bit eh;
    @(negedge clk);
    eh = m_hit(pc);
    check("busy", 32'(busy), 32'(busy_cnt != 0));
    check("hit", 32'(hit), 32'(eh));
    check("taken", 32'(tk), 32'(eh && mcnt[idx_of(pc)] >= 2));
    check("target", tgt, eh ? mta[idx_of(pc)] : 32'h0);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic v,
                       input logic [31:0] ua, input logic t,
                       input logic [31:0] ta, input logic f);
    pc   = a;
    uv   = v;
    upc  = ua;
    ut   = t;
    utgt = ta;
    fl   = f;
  endtask

  task automatic upd(input logic [31:0] ua, input logic t,
                     input logic [31:0] ta);
    drive(ua, 1'b1, ua, t, ta, 1'b0);
    cycle();
  endtask

  task automatic look(input string tag, input logic [31:0] a,
                      input logic eh, input logic et,
                      input logic [31:0] etgt);
    drive(a, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    #1;
    check({tag, "_hit"}, 32'(hit), 32'(eh));
    check({tag, "_taken"}, 32'(tk), 32'(et));
    check({tag, "_tgt"}, tgt, etgt);
    cycle();
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    busy_cnt = 64;
  endtask

  function automatic logic [31:0] rnd_pc();
    return (32'($urandom_range(0, 3)) << 8) |
           (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
  endfunction

  initial begin
    int busy_len;
    logic [31:0] a;
    for (int k = 0; k < 64; k++) begin
      mv[k] = 1'b0; mtag[k] = 0; mta[k] = '0; mcnt[k] = 1;
    end
    busy_cnt = 64;
    rst_n = 1'b0;
    drive(32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'h1);
    rst_n = 1'b1;

    // T1: busy length measured directly, updates during walk dropped
    busy_len = 0;
    while (busy && busy_len < 200) begin
      a = rnd_pc();
      drive(a, 1'b1, a, 1'b1, 32'h1234, 1'b0);
      cycle();
      busy_len++;
    end
    check("t1_busy_len", 32'(busy_len), 32'd64);
    look("t1_after", 32'h100, 1'b0, 1'b0, 32'h0);

    // T2: allocate
    upd(32'h100, 1'b1, 32'h200);
    look("t2", 32'h100, 1'b1, 1'b1, 32'h200);

    // T3: saturation
    upd(32'h100, 1'b1, 32'h200);
    upd(32'h100, 1'b1, 32'h200);
    upd(32'h100, 1'b0, 32'h0);
    look("t3_st_dec", 32'h100, 1'b1, 1'b1, 32'h200);
    upd(32'h100, 1'b0, 32'h0);
    upd(32'h100, 1'b0, 32'h0);
    look("t3_snt", 32'h100, 1'b1, 1'b0, 32'h200);
    upd(32'h100, 1'b0, 32'h0);
    upd(32'h100, 1'b1, 32'h200);
    look("t3_sat0", 32'h100, 1'b1, 1'b0, 32'h200);

    // T4: aliasing
    upd(32'h200, 1'b1, 32'h300);
    look("t4_old", 32'h100, 1'b0, 1'b0, 32'h0);
    look("t4_new", 32'h200, 1'b1, 1'b1, 32'h300);
    upd(32'h400, 1'b0, 32'h0);
    look("t4_nt", 32'h400, 1'b0, 1'b0, 32'h0);
    look("t4_keep", 32'h200, 1'b1, 1'b1, 32'h300);

    // T5: read-old on same-cycle update
    upd(32'h100, 1'b1, 32'h500);
    drive(32'h100, 1'b1, 32'h100, 1'b1, 32'h600, 1'b0);
    #1;
    check("t5_old", tgt, 32'h500);
    cycle();
    look("t5_new", 32'h100, 1'b1, 1'b1, 32'h600);

    // T6: flush beats update, reset mid-walk restarts
    drive(32'h100, 1'b1, 32'h104, 1'b1, 32'h700, 1'b1);
    cycle();
    for (int k = 0; k < 30; k++) begin
      drive(rnd_pc(), 1'b0, 32'h0, 1'b0, 32'h0, k == 5);
      cycle();
    end
    pulse_reset();
    busy_len = 0;
    while (busy && busy_len < 200) begin
      drive(rnd_pc(), 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      cycle();
      busy_len++;
    end
    check("t6_busy_len", 32'(busy_len), 32'd64);
    look("t6_104", 32'h104, 1'b0, 1'b0, 32'h0);
    look("t6_100", 32'h100, 1'b0, 1'b0, 32'h0);

    // random traffic
    for (int n = 0; n < 2000; n++) begin
      a = rnd_pc();
      drive(($urandom_range(0, 3) == 0) ? a : rnd_pc(),
            $urandom_range(0, 2) != 0, a, $urandom_range(0, 1) == 1,
            32'($urandom) & 32'hffff_fffc, $urandom_range(0, 299) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
